// File: rtl/sdram_ctrl_pkg.sv
// Shared types and constants for the SDRAM host controller: FSM states,
// host address field layout and {cs_l,ras_l,cas_l,wr_l} command encodings.
package sdram_ctrl_pkg;

    localparam int BANK_W   = 2;
    localparam int ROW_W    = 11;
    localparam int COL_W    = 11;
    localparam int ADDR_W   = BANK_W + ROW_W + COL_W;
    localparam int COL_LSB  = 0;
    localparam int ROW_LSB  = COL_LSB + COL_W;
    localparam int BANK_LSB = ROW_LSB + ROW_W;
    localparam int DATA_W   = 33;
    localparam int MASK_W   = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACTIVATE,
        ST_RCD_WAIT,
        ST_COLUMN,
        ST_WRITE,
        ST_READ_WAIT,
        ST_DONE,
        ST_REFRESH,
        ST_RFC_WAIT
    } state_e;

    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_ACT   = 4'b0011;
    localparam cmd_t CMD_COL   = 4'b0101;
    localparam cmd_t CMD_WRITE = 4'b0110;
    localparam cmd_t CMD_NOP   = 4'b0111;
    localparam cmd_t CMD_REF   = 4'b0001;
    localparam cmd_t CMD_DESEL = 4'b1111;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter; raises ref_pending on each wrap and
// holds it until the sequencer clears it. Repeated wraps do not queue.
module sdram_refresh_timer
    import sdram_ctrl_pkg::*;
#(
    parameter int REF_PERIOD = 1024
) (
    input  logic clk,
    input  logic sys_rst_l,
    input  logic ref_clr,
    output logic ref_pending
);

    localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             wrap;

    always_comb begin
        wrap   = (cnt_q == CNT_W'(REF_PERIOD - 1));
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        pend_d = pend_q;
        if (ref_clr) begin
            pend_d = 1'b0;
        end
        // A wrap on the clearing edge is a fresh request and must not be lost.
        if (wrap) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign ref_pending = pend_q;

endmodule

// File: rtl/sdram_host_ctrl.sv
// Single-beat host-to-SDRAM command sequencer. Pin outputs are decoded from the
// next state so every command appears registered in the cycle its state is live.
module sdram_host_ctrl
    import sdram_ctrl_pkg::*;
#(
    parameter int T_RCD      = 1,
    parameter int CAS_LAT    = 2,
    parameter int REF_PERIOD = 1024,
    parameter int T_RFC      = 4
) (
    input  logic              clk,
    input  logic              sys_rst_l,
    input  logic              host_req,
    output logic              host_ready,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [MASK_W-1:0] host_dqm,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_done,
    output logic [ROW_W-1:0]  sdram_addx,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [DATA_W-1:0] sdram_wdata,
    input  logic [DATA_W-1:0] sdram_rdata,
    output logic              sdram_cs_l,
    output logic              sdram_ras_l,
    output logic              sdram_cas_l,
    output logic              sdram_wr_l,
    output logic [MASK_W-1:0] sdram_dqm
);

    localparam int WAIT_W = 8;

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_lat_q, wdata_lat_d;
    logic [MASK_W-1:0]   dqm_lat_q, dqm_lat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    cmd_t                cmd_q, cmd_d;
    logic [MASK_W-1:0]   dqm_q, dqm_d;
    logic [ROW_W-1:0]    addx_q, addx_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [DATA_W-1:0]   sdram_wdata_q, sdram_wdata_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                host_done_q, host_done_d;
    logic                ref_pending;
    logic                ref_clr;

    sdram_refresh_timer #(
        .REF_PERIOD(REF_PERIOD)
    ) u_ref_timer (
        .clk        (clk),
        .sys_rst_l  (sys_rst_l),
        .ref_clr    (ref_clr),
        .ref_pending(ref_pending)
    );

    assign host_ready = (state_q == ST_IDLE) && !ref_pending;

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_lat_d  = wdata_lat_q;
        dqm_lat_d    = dqm_lat_q;
        wait_d       = wait_q;
        host_rdata_d = host_rdata_q;
        ref_clr      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Refresh takes priority over a waiting host request.
                if (ref_pending) begin
                    state_d = ST_REFRESH;
                    ref_clr = 1'b1;
                end else if (host_req) begin
                    state_d     = ST_ACTIVATE;
                    wr_d        = host_wr;
                    addr_d      = host_addr;
                    wdata_lat_d = host_wdata;
                    dqm_lat_d   = host_dqm;
                end
            end
            ST_ACTIVATE: begin
                if (T_RCD > 1) begin
                    state_d = ST_RCD_WAIT;
                    wait_d  = WAIT_W'(T_RCD - 2);
                end else begin
                    state_d = ST_COLUMN;
                end
            end
            ST_RCD_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_COLUMN;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_COLUMN: begin
                if (wr_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ_WAIT;
                    wait_d  = WAIT_W'(CAS_LAT - 1);
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
            end
            ST_READ_WAIT: begin
                if (wait_q == '0) begin
                    state_d      = ST_DONE;
                    host_rdata_d = sdram_rdata;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_REFRESH: begin
                if (T_RFC > 1) begin
                    state_d = ST_RFC_WAIT;
                    wait_d  = WAIT_W'(T_RFC - 2);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RFC_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values for the state being entered; bank only moves on ACTIVATE so it
    // stays stable through the whole access.
    always_comb begin
        cmd_d         = CMD_DESEL;
        dqm_d         = 4'hF;
        addx_d        = addx_q;
        bank_d        = bank_q;
        sdram_wdata_d = sdram_wdata_q;
        host_done_d   = 1'b0;

        unique case (state_d)
            ST_ACTIVATE: begin
                cmd_d  = CMD_ACT;
                addx_d = addr_d[ROW_LSB +: ROW_W];
                bank_d = addr_d[BANK_LSB +: BANK_W];
            end
            ST_RCD_WAIT: begin
                cmd_d = CMD_NOP;
            end
            ST_COLUMN: begin
                cmd_d  = CMD_COL;
                addx_d = addr_d[COL_LSB +: COL_W];
            end
            ST_WRITE: begin
                cmd_d         = CMD_WRITE;
                sdram_wdata_d = wdata_lat_d;
                dqm_d         = dqm_lat_d;
            end
            ST_READ_WAIT: begin
                cmd_d = CMD_NOP;
                dqm_d = 4'h0;
            end
            ST_DONE: begin
                host_done_d = 1'b1;
            end
            ST_REFRESH: begin
                cmd_d = CMD_REF;
            end
            default: begin
                cmd_d = CMD_DESEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q       <= ST_IDLE;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_lat_q   <= '0;
            dqm_lat_q     <= '0;
            wait_q        <= '0;
            cmd_q         <= CMD_DESEL;
            dqm_q         <= 4'hF;
            addx_q        <= '0;
            bank_q        <= '0;
            sdram_wdata_q <= '0;
            host_rdata_q  <= '0;
            host_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_lat_q   <= wdata_lat_d;
            dqm_lat_q     <= dqm_lat_d;
            wait_q        <= wait_d;
            cmd_q         <= cmd_d;
            dqm_q         <= dqm_d;
            addx_q        <= addx_d;
            bank_q        <= bank_d;
            sdram_wdata_q <= sdram_wdata_d;
            host_rdata_q  <= host_rdata_d;
            host_done_q   <= host_done_d;
        end
    end

    assign {sdram_cs_l, sdram_ras_l, sdram_cas_l, sdram_wr_l} = cmd_q;
    assign sdram_dqm   = dqm_q;
    assign sdram_addx  = addx_q;
    assign sdram_bank  = bank_q;
    assign sdram_wdata = sdram_wdata_q;
    assign host_rdata  = host_rdata_q;
    assign host_done   = host_done_q;

endmodule

// File: tb/tb_sdram_host_ctrl.sv
// Bench for sdram_host_ctrl: pin-level SDRAM model, host-level reference memory,
// refresh-rule monitor, directed cases and randomized traffic.
`timescale 1ns/1ps
module tb_sdram_host_ctrl;

    localparam int REF_P = 16;
    localparam int RFC   = 4;

    logic        clk = 1'b0;
    logic        sys_rst_l = 1'b0;
    logic        host_req = 1'b0;
    logic        host_ready;
    logic        host_wr = 1'b0;
    logic [23:0] host_addr = '0;
    logic [32:0] host_wdata = '0;
    logic [3:0]  host_dqm = '0;
    logic [32:0] host_rdata;
    logic        host_done;
    logic [10:0] sdram_addx;
    logic [1:0]  sdram_bank;
    logic [32:0] sdram_wdata;
    logic [32:0] sdram_rdata = '0;
    logic        sdram_cs_l, sdram_ras_l, sdram_cas_l, sdram_wr_l;
    logic [3:0]  sdram_dqm;

    always #5 clk = ~clk;

    sdram_host_ctrl #(
        .T_RCD(1), .CAS_LAT(2), .REF_PERIOD(REF_P), .T_RFC(RFC)
    ) dut (
        .clk(clk), .sys_rst_l(sys_rst_l),
        .host_req(host_req), .host_ready(host_ready), .host_wr(host_wr),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_dqm(host_dqm),
        .host_rdata(host_rdata), .host_done(host_done),
        .sdram_addx(sdram_addx), .sdram_bank(sdram_bank),
        .sdram_wdata(sdram_wdata), .sdram_rdata(sdram_rdata),
        .sdram_cs_l(sdram_cs_l), .sdram_ras_l(sdram_ras_l),
        .sdram_cas_l(sdram_cas_l), .sdram_wr_l(sdram_wr_l),
        .sdram_dqm(sdram_dqm)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Byte-masked merge: unmasked bytes update, bit 32 only on an unmasked write.
    function automatic logic [32:0] merge(input logic [32:0] old, input logic [32:0] nw,
                                          input logic [3:0] m);
        logic [32:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (!m[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        if (m == 4'h0) r[32] = nw[32];
        return r;
    endfunction

    logic [3:0] cmd;
    assign cmd = {sdram_cs_l, sdram_ras_l, sdram_cas_l, sdram_wr_l};

    // Pin-level memory, driven purely by what appears on the SDRAM pins.
    logic [32:0] pin_mem [logic [23:0]];
    logic [10:0] pm_row = '0;
    logic [10:0] pm_col = '0;

    always @(negedge clk) begin
        logic [23:0] k;
        if (cmd == 4'b0011) pm_row = sdram_addx;
        if (cmd == 4'b0101) pm_col = sdram_addx;
        k = {sdram_bank, pm_row, pm_col};
        if (cmd == 4'b0110)
            pin_mem[k] = merge(pin_mem.exists(k) ? pin_mem[k] : 33'h0, sdram_wdata, sdram_dqm);
        sdram_rdata = pin_mem.exists(k) ? pin_mem[k] : 33'h0;
    end

    // Host-level reference memory, updated from accepted requests only.
    logic [32:0] ref_mem [logic [23:0]];

    function automatic logic [32:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 33'h0;
    endfunction

    // Refresh model: a request becomes due every REF_P clocks after reset.
    int rc = 0;
    int age = 0;
    int ref_cnt = 0;
    bit m_pend = 1'b0;

    always @(negedge clk) begin
        if (!sys_rst_l) begin
            rc = 0;
            m_pend = 1'b0;
            age = 0;
        end else begin
            rc++;
            if (cmd == 4'b0001) begin
                ref_cnt++;
                chk("ref_was_due", {63'd0, m_pend}, 64'd1);
                chk("ref_age_ok", {63'd0, (age <= 10)}, 64'd1);
                m_pend = 1'b0;
                age = 0;
            end
            if (rc % REF_P == 0) m_pend = 1'b1;
            if (m_pend) begin
                age++;
                chk("ready_low_ref_due", {63'd0, host_ready}, 64'd0);
            end
        end
    end

    task automatic txn(input logic wr, input logic [23:0] a, input logic [32:0] d,
                       input logic [3:0] m, output int waited);
        logic [32:0] exp_rd;
        int done_i;
        @(negedge clk);
        host_req = 1'b1; host_wr = wr; host_addr = a; host_wdata = d; host_dqm = m;
        waited = 0;
        while (!host_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!host_ready) begin
            chk("accept_timeout", {63'd0, host_ready}, 64'd1);
            host_req = 1'b0;
            return;
        end
        exp_rd = ref_rd(a);
        if (wr) ref_mem[a] = merge(exp_rd, d, m);
        done_i = wr ? 4 : 5;
        for (int i = 1; i <= done_i; i++) begin
            @(negedge clk);
            host_req = 1'b0;
            host_wdata = {$urandom_range(1, 0), $urandom};
            host_dqm = 4'($urandom);
            chk("done_timing", {63'd0, host_done}, {63'd0, (i == done_i)});
            if (i < done_i) chk("bank_held", {62'd0, sdram_bank}, {62'd0, a[23:22]});
            if (i == 1) begin
                chk("act_cmd", {60'd0, cmd}, 64'h3);
                chk("act_row", {53'd0, sdram_addx}, {53'd0, a[21:11]});
            end else if (i == 2) begin
                chk("col_cmd", {60'd0, cmd}, 64'h5);
                chk("col_addr", {53'd0, sdram_addx}, {53'd0, a[10:0]});
            end else if (i == 3 && wr) begin
                chk("wr_cmd", {60'd0, cmd}, 64'h6);
                chk("wr_data", {31'd0, sdram_wdata}, {31'd0, d});
                chk("wr_dqm", {60'd0, sdram_dqm}, {60'd0, m});
            end else if (i < done_i && !wr) begin
                chk("rdwait_cmd", {60'd0, cmd}, 64'h7);
                chk("rdwait_dqm", {60'd0, sdram_dqm}, 64'h0);
            end else if (i == done_i) begin
                chk("done_cmd", {60'd0, cmd}, 64'hF);
                if (!wr) chk("rd_data", {31'd0, host_rdata}, {31'd0, exp_rd});
            end
        end
    endtask

    task automatic rst_mid_read(input logic [23:0] a);
        int n;
        @(negedge clk);
        host_req = 1'b1; host_wr = 1'b0; host_addr = a;
        n = 0;
        while (!host_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rst_accept", {63'd0, host_ready}, 64'd1);
        @(negedge clk);
        host_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_rdwait", {60'd0, cmd}, 64'h7);
        #2 sys_rst_l = 1'b0;
        #1;
        chk("rst_cmd", {60'd0, cmd}, 64'hF);
        chk("rst_dqm", {60'd0, sdram_dqm}, 64'hF);
        chk("rst_addx", {53'd0, sdram_addx}, 64'd0);
        chk("rst_bank", {62'd0, sdram_bank}, 64'd0);
        chk("rst_rdata", {31'd0, host_rdata}, 64'd0);
        chk("rst_done", {63'd0, host_done}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", {63'd0, host_done}, 64'd0);
        end
        #2 sys_rst_l = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, host_ready}, 64'd1);
        chk("idle_cmd_after_rst", {60'd0, cmd}, 64'hF);
    endtask

    initial begin
        int w;
        int refs_before;
        logic [23:0] a;

        repeat (3) @(negedge clk);
        chk("reset_cmd", {60'd0, cmd}, 64'hF);
        chk("reset_dqm", {60'd0, sdram_dqm}, 64'hF);
        chk("reset_addx", {53'd0, sdram_addx}, 64'd0);
        chk("reset_bank", {62'd0, sdram_bank}, 64'd0);
        chk("reset_wdata", {31'd0, sdram_wdata}, 64'd0);
        chk("reset_rdata", {31'd0, host_rdata}, 64'd0);
        chk("reset_done", {63'd0, host_done}, 64'd0);
        chk("reset_ready", {63'd0, host_ready}, 64'd1);
        #2 sys_rst_l = 1'b1;

        a = {2'd0, 11'd1, 11'd5};
        txn(1'b1, a, 33'h0DEADBEEF, 4'h0, w);
        txn(1'b0, a, 33'h0, 4'h0, w);
        chk("basic_rd", {31'd0, host_rdata}, {31'd0, 33'h0DEADBEEF});

        a = {2'd1, 11'd20, 11'd300};
        txn(1'b1, a, 33'h012345678, 4'h0, w);
        txn(1'b1, a, 33'h0AABBCCDD, 4'b1100, w);
        txn(1'b0, a, 33'h0, 4'h0, w);
        chk("masked_rd", {31'd0, host_rdata}, {31'd0, 33'h01234CCDD});

        a = {2'd3, 11'd7, 11'd10};
        txn(1'b1, a, 33'h1FFFFFFFF, 4'h0, w);
        txn(1'b0, a, 33'h0, 4'h0, w);
        chk("b2b_rd", {31'd0, host_rdata}, {31'd0, 33'h1FFFFFFFF});

        // Hold a request across a refresh-counter wrap.
        while (rc % REF_P != REF_P - 1) @(negedge clk);
        refs_before = ref_cnt;
        txn(1'b0, {2'd0, 11'd1, 11'd5}, 33'h0, 4'h0, w);
        chk("ref_wait_cycles", 64'(w), 64'(RFC + 1));
        chk("ref_before_act", 64'(ref_cnt - refs_before), 64'd1);
        chk("ref_rd", {31'd0, host_rdata}, {31'd0, 33'h0DEADBEEF});

        rst_mid_read({2'd3, 11'd7, 11'd10});

        for (int t = 0; t < 80; t++) begin
            logic rw;
            logic [3:0] m;
            a = {2'($urandom), 11'($urandom_range(2, 0)), 11'($urandom_range(2, 0))};
            rw = 1'($urandom);
            m = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom);
            txn(rw, a, {1'($urandom), $urandom}, m, w);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        chk("ref_not_stuck", {63'd0, (m_pend && age > 10)}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdram_host_ctrl.md
Name: sdram_host_ctrl

Overview:
Command sequencer sitting directly upstream of the SDRAM memory model. It takes single-beat host read/write requests over a valid/ready handshake and drives the SDRAM pins: chip select, RAS, CAS, write enable, DQM, bank and the multiplexed row/column address. It returns read data to the host and inserts periodic refresh commands.

Parameters:
T_RCD, 1, cycles from ACTIVATE to COLUMN (>=1)
CAS_LAT, 2, cycles from end of COLUMN to read-data capture (>=2)
REF_PERIOD, 1024, cycles between refresh requests
T_RFC, 4, cycles a refresh occupies including its command cycle (>=1)

Ports:
clk  in  1  clock
sys_rst_l  in  1  reset, asynchronous, active-low
host_req  in  1  request valid
host_ready  out  1  controller can accept a request
host_wr  in  1  1=write, 0=read
host_addr  in  24  {bank[23:22], row[21:11], col[10:0]}
host_wdata  in  33  write data
host_dqm  in  4  byte mask for writes (1=masked)
host_rdata  out  33  read data, valid while host_done=1 on a read
host_done  out  1  one-cycle completion pulse
sdram_addx  out  11  row/column address
sdram_bank  out  2  bank select
sdram_wdata  out  33  to memory data input
sdram_rdata  in  33  from memory data output
sdram_cs_l, sdram_ras_l, sdram_cas_l, sdram_wr_l  out  1 each  command pins
sdram_dqm  out  4  data mask

Behaviour:
- All outputs registered except host_ready = (state==IDLE) && !ref_pending.
- Reset values: cs_l/ras_l/cas_l/wr_l=1, dqm=4'hF, addx=0, bank=0, wdata=0, host_rdata=0, host_done=0, state=IDLE, ref counter=0, ref_pending=0.
- Accept on the clk edge where host_req && host_ready; latch wr, addr, wdata, dqm.
- States: IDLE, ACTIVATE, RCD_WAIT, COLUMN, WRITE, READ_WAIT, DONE, REFRESH, RFC_WAIT.
- ACTIVATE (1 cycle): cs_l=0, ras_l=0, cas_l=1, wr_l=1, addx=row, bank=bank.
- RCD_WAIT (T_RCD-1 cycles, skipped if T_RCD=1): cs_l=0, ras_l=cas_l=1.
- COLUMN (1 cycle): cs_l=0, ras_l=1, cas_l=0, addx=col.
- WRITE (1 cycle): cs_l=0, ras_l=cas_l=1, wr_l=0, wdata and dqm driven from latched values -> DONE.
- READ_WAIT (CAS_LAT cycles): cs_l=0, ras_l=cas_l=1, wr_l=1, dqm=4'h0; capture sdram_rdata into host_rdata on the last READ_WAIT edge -> DONE.
- bank held constant from ACTIVATE through the end of WRITE/READ_WAIT (memory samples the bank on every selected cycle and reads with live bank).
- DONE (1 cycle): host_done=1, cs_l=1, dqm=4'hF, wr_l=1 -> IDLE.
- Latency, defaults: write done in 4th cycle after accept; read done in 5th cycle after accept.
- Refresh: free-running counter 0..REF_PERIOD-1 wraps and sets ref_pending; a second wrap while pending stays pending (no queuing). In IDLE with ref_pending, go to REFRESH regardless of host_req (refresh wins, host_ready=0). REFRESH (1 cycle): cs_l=0, ras_l=0, cas_l=0, wr_l=1; clears ref_pending. RFC_WAIT T_RFC-1 cycles with cs_l=1, then IDLE.
- Refresh due mid-transaction: transaction completes unchanged; refresh runs before the next accept.
- Bit 32 of write data passes through; masked writes (dqm!=0) update only unmasked bytes in memory, bit 32 unchanged.
- Reset mid-operation: abort immediately, all outputs to reset values, no host_done.
- No back-pressure on host_done; next accept possible the cycle after DONE.

Decomposition:
- Package sdram_ctrl_pkg: state enum, address field widths/offsets (BANK_W=2, ROW_W=11, COL_W=11), data width 33, mask width 4, command encodings {cs_l,ras_l,cas_l,wr_l} for ACT, COL, WRITE, NOP, REF, DESEL.
- Sub-module sdram_refresh_timer: counter plus ref_pending, with clear input.

Test Plan:
- Write addr {2'd0,11'd1,11'd5}, data 33'h0DEADBEEF, dqm 0 -> pin sequence ACT(row 1)/COL(col 5)/WRITE, host_done in 4th cycle; read same addr returns 33'h0DEADBEEF, host_done in 5th cycle.
- Preload 33'h012345678, write 33'h0AABBCCDD with dqm 4'b1100 -> read returns 33'h01234CCDD.
- REF_PERIOD=16: host_req held at counter wrap -> host_ready=0, REF command (cs/ras/cas low) before ACT, request served after T_RFC.
- Back-to-back write then read to bank 3 row 7 col 10, data 33'h1FFFFFFFF -> read returns 33'h1FFFFFFFF, bank pins =3 throughout both transactions.
- Assert sys_rst_l low during READ_WAIT -> all command pins 1, dqm 4'hF, no host_done; host_ready=1 one cycle after release.
- Read with wdata/dqm inputs toggling -> sdram_dqm=0 and wr_l=1 during READ_WAIT, data unaffected.
